// File: rtl/board_pkg.sv
// Shared types, board dimensions and colour helper for the triangle feeder.
package board_pkg;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int COORD_W    = 20;
  localparam int COLOR_W    = 12;

  typedef logic [2:0] cell_color_t;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } vertex_t;

  typedef struct packed {
    vertex_t [2:0]      v;
    logic [COLOR_W-1:0] color;
  } triangle_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_EMIT0 = 3'd2,
    ST_EMIT1 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Each colour bit becomes a full-intensity or dark nibble: {b,g,r} -> {B,G,R}.
  function automatic logic [COLOR_W-1:0] expand_color(input cell_color_t c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

endpackage

// File: rtl/board_triangle_feeder_if.sv
// Triangle stream from the board feeder to the rasterizer (valid/ready).
interface board_triangle_feeder_if;
  import board_pkg::*;

  logic                          tri_valid;
  logic                          tri_ready;
  logic [2:0][COORD_W-1:0]       tri_x;
  logic [2:0][COORD_W-1:0]       tri_y;
  logic [COLOR_W-1:0]            tri_color;

  modport master (
    output tri_valid, tri_x, tri_y, tri_color,
    input  tri_ready
  );

  modport slave (
    input  tri_valid, tri_x, tri_y, tri_color,
    output tri_ready
  );

endinterface

// File: rtl/cell_geometry.sv
// Combinational mapping of a board cell and triangle select to screen-space vertices.
module cell_geometry
  import board_pkg::*;
#(
  parameter int ROW_W    = 5,
  parameter int COL_W    = 4,
  parameter int X_OFFSET = 24,
  parameter int Y_OFFSET = 24,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input  logic [ROW_W-1:0]          row_i,
  input  logic [COL_W-1:0]          col_i,
  input  logic                      tri_sel_i,
  output logic [2:0][COORD_W-1:0]   x_o,
  output logic [2:0][COORD_W-1:0]   y_o
);

  logic signed [COORD_W-1:0] xl_s;
  logic signed [COORD_W-1:0] xr_s;
  logic signed [COORD_W-1:0] yt_s;
  logic signed [COORD_W-1:0] yb_s;

  // Both triangles share the (xL,yT)-(xR,yB) diagonal; vertex order keeps edge functions non-negative inside.
  always_comb begin
    xl_s = COORD_W'(X_ORIGIN + int'(col_i) * X_OFFSET);
    yt_s = COORD_W'(Y_ORIGIN + int'(row_i) * Y_OFFSET);
    xr_s = xl_s + COORD_W'(X_OFFSET);
    yb_s = yt_s + COORD_W'(Y_OFFSET);
    if (tri_sel_i) begin
      x_o = {xr_s, xr_s, xl_s};
      y_o = {yb_s, yt_s, yt_s};
    end else begin
      x_o = {xl_s, xr_s, xl_s};
      y_o = {yb_s, yb_s, yt_s};
    end
  end

endmodule

// File: rtl/board_triangle_feeder.sv
// Snapshots the game board on frame start and streams two triangles per occupied cell.
module board_triangle_feeder
  import board_pkg::*;
#(
  parameter int COLS     = BOARD_COLS,
  parameter int ROWS     = BOARD_ROWS,
  parameter int X_OFFSET = 24,
  parameter int Y_OFFSET = 24,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0
) (
  input  logic                           vclock_in,
  input  logic                           reset_n_in,
  input  logic                           frame_start_in,
  input  cell_color_t [ROWS*COLS-1:0]    board_in,
  board_triangle_feeder_if.master        tri_bus,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           overrun_out
);

  localparam int NCELL = ROWS * COLS;
  localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELL - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t                      state_q;
  cell_color_t [NCELL-1:0]     snapshot_q;
  logic [IDX_W-1:0]            index_q;
  logic [IDX_W-1:0]            index_d;
  logic [ROW_W-1:0]            row_q;
  logic [ROW_W-1:0]            row_d;
  logic [COL_W-1:0]            col_q;
  logic [COL_W-1:0]            col_d;
  logic                        valid_q;
  logic [2:0][COORD_W-1:0]     x_q;
  logic [2:0][COORD_W-1:0]     y_q;
  logic [COLOR_W-1:0]          color_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        overrun_q;

  cell_color_t                 cell_s;
  logic                        hs_s;
  logic                        last_s;
  logic                        tri_sel_s;
  logic [2:0][COORD_W-1:0]     geo_x_s;
  logic [2:0][COORD_W-1:0]     geo_y_s;

  assign cell_s    = snapshot_q[index_q];
  assign hs_s      = valid_q && tri_bus.tri_ready;
  assign last_s    = (index_q == LAST_IDX);
  assign tri_sel_s = (state_q == ST_EMIT0);

  // Row/column track the linear index so geometry never needs a divide.
  always_comb begin
    index_d = index_q + IDX_W'(1);
    if (col_q == LAST_COL) begin
      col_d = '0;
      row_d = row_q + ROW_W'(1);
    end else begin
      col_d = col_q + COL_W'(1);
      row_d = row_q;
    end
  end

  cell_geometry #(
    .ROW_W    (ROW_W),
    .COL_W    (COL_W),
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET),
    .X_ORIGIN (X_ORIGIN),
    .Y_ORIGIN (Y_ORIGIN)
  ) u_geom (
    .row_i     (row_q),
    .col_i     (col_q),
    .tri_sel_i (tri_sel_s),
    .x_o       (geo_x_s),
    .y_o       (geo_y_s)
  );

  // Scan/emit state machine with all outputs registered.
  always_ff @(posedge vclock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      snapshot_q <= '0;
      index_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (frame_start_in && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_start_in) begin
            snapshot_q <= board_in;
            index_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cell_s != 3'd0) begin
            x_q     <= geo_x_s;
            y_q     <= geo_y_s;
            color_q <= expand_color(cell_s);
            valid_q <= 1'b1;
            state_q <= ST_EMIT0;
          end else if (last_s) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            index_q <= index_d;
            row_q   <= row_d;
            col_q   <= col_d;
          end
        end
        ST_EMIT0: begin
          if (hs_s) begin
            x_q     <= geo_x_s;
            y_q     <= geo_y_s;
            state_q <= ST_EMIT1;
          end
        end
        ST_EMIT1: begin
          if (hs_s) begin
            valid_q <= 1'b0;
            if (last_s) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              index_q <= index_d;
              row_q   <= row_d;
              col_q   <= col_d;
              state_q <= ST_SCAN;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tri_bus.tri_valid = valid_q;
  assign tri_bus.tri_x     = x_q;
  assign tri_bus.tri_y     = y_q;
  assign tri_bus.tri_color = color_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign overrun_out       = overrun_q;

endmodule

// File: tb/tb_board_triangle_feeder.sv
// Scoreboard bench: a cell-list reference model queues expected triangles, a monitor pops them on handshakes.
module tb_board_triangle_feeder;
  import board_pkg::*;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int NCELL = COLS * ROWS;
  localparam int CELL  = 24;

  typedef logic [NCELL-1:0][2:0] board_t;

  typedef struct packed {
    logic [2:0][19:0] x;
    logic [2:0][19:0] y;
    logic [11:0]      col;
  } exp_tri_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   frame_start = 1'b0;
  board_t board = '0;
  logic   busy;
  logic   done;
  logic   overrun;
  int     cyc = 0;

  board_triangle_feeder_if bus ();

  board_triangle_feeder dut (
    .vclock_in      (clk),
    .reset_n_in     (rst_n),
    .frame_start_in (frame_start),
    .board_in       (board),
    .tri_bus        (bus),
    .busy_out       (busy),
    .done_out       (done),
    .overrun_out    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  exp_tri_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int first_valid_cyc;
  int done_cnt;
  int done_cyc;
  int tri_cnt;
  int last_hs_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: every non-empty cell, in row-major order, yields two triangles of its colour.
  task automatic model_frame(input board_t b, output int n_tri);
    n_tri = 0;
    for (int idx = 0; idx < NCELL; idx++) begin
      if (b[idx] != 3'd0) begin
        int r, c, l, rt, t, bt;
        exp_tri_t e;
        r  = idx / COLS;
        c  = idx % COLS;
        l  = c * CELL;
        rt = l + CELL;
        t  = r * CELL;
        bt = t + CELL;
        e.col = {b[idx][2] ? 4'hF : 4'h0, b[idx][1] ? 4'hF : 4'h0, b[idx][0] ? 4'hF : 4'h0};
        e.x[0] = 20'(l);  e.y[0] = 20'(t);
        e.x[1] = 20'(rt); e.y[1] = 20'(bt);
        e.x[2] = 20'(l);  e.y[2] = 20'(bt);
        exp_q.push_back(e);
        e.x[1] = 20'(rt); e.y[1] = 20'(t);
        e.x[2] = 20'(rt); e.y[2] = 20'(bt);
        exp_q.push_back(e);
        n_tri += 2;
      end
    end
  endtask

  task automatic monitor();
    logic [2:0][19:0] px, py;
    logic [11:0]      pc;
    bit               stalled;
    exp_tri_t         e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (bus.tri_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (stalled) begin
            chk("stall_x", 64'(bus.tri_x), 64'(px));
            chk("stall_y", 64'(bus.tri_y), 64'(py));
            chk("stall_color", 64'(bus.tri_color), 64'(pc));
          end
          if (bus.tri_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_triangle: actual=unexpected triangle required=none (t=%0t)", $time);
            end else begin
              e = exp_q.pop_front();
              chk("tri_x", 64'(bus.tri_x), 64'(e.x));
              chk("tri_y", 64'(bus.tri_y), 64'(e.y));
              chk("tri_color", 64'(bus.tri_color), 64'(e.col));
            end
            tri_cnt++;
            last_hs_cyc = cyc + 1;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            px = bus.tri_x;
            py = bus.tri_y;
            pc = bus.tri_color;
          end
        end else begin
          stalled = 1'b0;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
        end
      end
    end
  endtask

  task automatic clear_stats();
    first_valid_cyc = -1;
    done_cnt        = 0;
    done_cyc        = -1;
    tri_cnt         = 0;
    last_hs_cyc     = -1;
  endtask

  task automatic start_frame(input board_t b, output int n, output int n_tri);
    @(posedge clk); #1;
    board = b;
    frame_start = 1'b1;
    n = cyc + 1;
    clear_stats();
    model_frame(b, n_tri);
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      if (rnd_ready) bus.tri_ready = 1'($urandom_range(0, 1));
      k++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual=no done_out in %0d cycles required=done pulse", budget);
    end
    bus.tri_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_single_pulse", 64'(done_cnt), 64'(1));
    chk("busy_low_after_done", 64'(busy), 64'(0));
  endtask

  task automatic rand_board(input int pct, output board_t b);
    for (int idx = 0; idx < NCELL; idx++) begin
      b[idx] = (int'($urandom_range(0, 99)) < pct) ? 3'($urandom_range(1, 7)) : 3'd0;
    end
  endtask

  initial begin
    board_t b, b2;
    int     n, n_tri, k;

    bus.tri_ready = 1'b1;
    clear_stats();
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.tri_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_x", 64'(bus.tri_x), 64'(0));
    chk("rst_color", 64'(bus.tri_color), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    // Empty board
    b = '0;
    start_frame(b, n, n_tri);
    chk("busy_after_start", 64'(busy), 64'(1));
    wait_done(400, 1'b0);
    chk("empty_done_cycle", 64'(done_cyc), 64'(n + 200));
    chk("empty_no_valid", 64'(first_valid_cyc), 64'(-1));
    chk("empty_tri_count", 64'(tri_cnt), 64'(0));

    // Only cell (0,0) = 3'b101
    b = '0;
    b[0] = 3'b101;
    start_frame(b, n, n_tri);
    wait_done(400, 1'b0);
    chk("c00_first_valid", 64'(first_valid_cyc), 64'(n + 1));
    chk("c00_done_cycle", 64'(done_cyc), 64'(n + 202));
    chk("c00_tri_count", 64'(tri_cnt), 64'(2));

    // Only cell (19,9) = 3'b010
    b = '0;
    b[19 * COLS + 9] = 3'b010;
    start_frame(b, n, n_tri);
    wait_done(400, 1'b0);
    chk("c199_done_after_t1", 64'(done_cyc), 64'(last_hs_cyc));
    chk("c199_done_cycle", 64'(done_cyc), 64'(n + 202));
    chk("c199_tri_count", 64'(tri_cnt), 64'(2));

    // Stall on cell (0,0) for 5 cycles
    b = '0;
    b[0] = 3'b001;
    bus.tri_ready = 1'b0;
    start_frame(b, n, n_tri);
    k = 0;
    while (!bus.tri_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("stall_valid_seen", 64'(bus.tri_valid), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_handshake", 64'(tri_cnt), 64'(0));
    bus.tri_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_valid", 64'(bus.tri_valid), 64'(1));
    chk("t1_x1", 64'(bus.tri_x[1]), 64'(24));
    chk("t1_y1", 64'(bus.tri_y[1]), 64'(0));
    wait_done(400, 1'b0);
    chk("stall_tri_count", 64'(tri_cnt), 64'(2));

    // Full board, ready high
    rand_board(100, b);
    start_frame(b, n, n_tri);
    wait_done(1000, 1'b0);
    chk("full_done_cycle", 64'(done_cyc), 64'(n + 600));
    chk("full_tri_count", 64'(tri_cnt), 64'(400));

    // Random boards with random backpressure
    for (int f = 0; f < 3; f++) begin
      rand_board(25, b);
      start_frame(b, n, n_tri);
      wait_done(3000, 1'b1);
      chk("rand_tri_count", 64'(tri_cnt), 64'(n_tri));
    end
    chk("no_overrun_yet", 64'(overrun), 64'(0));

    // Restart attempt and board change mid-scan
    rand_board(30, b);
    start_frame(b, n, n_tri);
    repeat (40) begin
      @(posedge clk); #1;
      bus.tri_ready = 1'($urandom_range(0, 1));
    end
    rand_board(60, b2);
    board = b2;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_done(3000, 1'b1);
    chk("overrun_tri_count", 64'(tri_cnt), 64'(n_tri));
    chk("overrun_sticky", 64'(overrun), 64'(1));

    // Asynchronous reset while a triangle is held in EMIT0
    b = '0;
    b[5] = 3'b111;
    bus.tri_ready = 1'b0;
    start_frame(b, n, n_tri);
    k = 0;
    while (!bus.tri_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("pre_reset_valid", 64'(bus.tri_valid), 64'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.tri_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_overrun", 64'(overrun), 64'(0));
    chk("async_rst_x", 64'(bus.tri_x), 64'(0));
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    clear_stats();
    bus.tri_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_no_valid", 64'(first_valid_cyc), 64'(-1));
    chk("post_reset_busy", 64'(busy), 64'(0));
    chk("post_reset_no_done", 64'(done_cnt), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_triangle_feeder.md
Name: board_triangle_feeder

Overview:
- Producer side of the triangle interface consumed by the edge-function rasterizer.
- Latches a snapshot of the 10x20 game board at each frame start.
- Walks the snapshot row-major and emits two screen-space triangles, with a 12-bit colour, for every occupied cell.
- Uses a valid/ready handshake so the rasterizer can stall emission.

Parameters:
- COLS, 10, board columns (j index).
- ROWS, 20, board rows (i index).
- X_OFFSET, 24, cell width in pixels.
- Y_OFFSET, 24, cell height in pixels.
- X_ORIGIN, 0, screen x of cell (0,0) left edge.
- Y_ORIGIN, 0, screen y of cell (0,0) top edge.

Ports:
- vclock_in  input  1  video clock; all state on rising edge.
- reset_n_in  input  1  reset, asynchronous, active-low.
- frame_start_in  input  1  one-cycle pulse; snapshot board and begin a scan.
- board_in  input  ROWS*COLS x 3  per-cell colour code {b,g,r}; cell index = i*COLS+j; 0 = empty.
- tri_valid_out  output  1  triangle on tri_* is valid.
- tri_ready_in  input  1  rasterizer accepts the triangle this cycle.
- tri_x_out  output  3 x 20 signed  vertex x[0..2].
- tri_y_out  output  3 x 20 signed  vertex y[0..2].
- tri_color_out  output  12  {b*15, g*15, r*15} nibbles: [3:0]=r, [7:4]=g, [11:8]=b.
- busy_out  output  1  scan in progress.
- done_out  output  1  one-cycle pulse when the scan completes.
- overrun_out  output  1  sticky: frame_start_in arrived while busy.

Behaviour:
- Reset (async, immediate on reset_n_in low):
  - state=IDLE; snapshot=0; index=0.
  - All outputs 0, including tri_valid_out, done_out and overrun_out; this holds mid-emission as well.
- States: IDLE, SCAN, EMIT0, EMIT1, DONE.
- IDLE: frame_start_in=1 sampled at edge N -> snapshot<=board_in, index<=0, state<=SCAN, busy_out=1 from edge N.
- SCAN, one cell per cycle:
  - Cell empty: if index==ROWS*COLS-1, go to DONE; else index+1.
  - Cell occupied: register the triangle-0 vertices and colour, tri_valid_out<=1, state<=EMIT0.
- EMIT0:
  - While tri_valid_out && !tri_ready_in, every tri_* output is held bit-stable.
  - On handshake, load triangle 1, keep valid=1, state<=EMIT1.
- EMIT1: on handshake, tri_valid_out<=0; if last index go to DONE, else index+1 and state SCAN.
- DONE: done_out=1 for exactly one cycle; busy_out<=0; state<=IDLE.
- Geometry, with xL=X_ORIGIN+j*X_OFFSET, xR=xL+X_OFFSET, yT=Y_ORIGIN+i*Y_OFFSET, yB=yT+Y_OFFSET:
  - Triangle 0: (xL,yT),(xR,yB),(xL,yB).
  - Triangle 1: (xL,yT),(xR,yT),(xR,yB).
  - Both are wound so that the rasterizer's e1,e2,e3 >= 0 inside; the diagonal is shared.
- Width and colour rules:
  - Arithmetic in 20-bit signed; no saturation (defaults give at most 240 x 480).
  - Colour is per-bit expansion: bit -> 4'hF or 4'h0. The colour is identical for both triangles of a cell.
- Latency: empty board -> done_out high in the cycle after edge N+ROWS*COLS (N+200).
  - With ready tied high, each occupied cell costs 3 cycles.
  - A full board therefore completes at edge N+600, emitting 400 triangles.
- frame_start_in while busy_out=1 (any non-IDLE state, including DONE): ignored, scan unaffected, overrun_out<=1 until reset.
- board_in changes during a scan have no effect; only the snapshot is read.
- tri_ready_in is ignored while tri_valid_out=0.

Decomposition:
- board_pkg holds:
  - constants BOARD_COLS, BOARD_ROWS;
  - typedef cell_color_t (3-bit);
  - typedef vertex_t {x,y} (signed 20);
  - typedef triangle_t (vertex_t[3] + 12-bit colour);
  - function expand_color (3 -> 12 bits).
- One combinational sub-module, cell_geometry: (i, j, tri_sel) -> triangle vertices, parameterised by offsets and origins.

Test Plan:
- Empty board, start pulse, ready=1 -> no tri_valid_out ever; done_out single pulse in the cycle after edge N+200; busy_out low afterwards.
- Only cell (0,0)=3'b101, ready=1:
  - T0 = (0,0),(24,24),(0,24), colour 12'hF0F;
  - T1 = (0,0),(24,0),(24,24), colour 12'hF0F;
  - valid first seen after edge N+1; done after edge N+202.
- Only cell (19,9)=3'b010 -> T0 = (216,456),(240,480),(216,480), colour 12'h0F0; done immediately after the T1 handshake.
- Cell (0,0) occupied, ready held low 5 cycles -> tri_* stable for all 5 cycles; T1 appears exactly one edge after ready rises.
- Second frame_start_in mid-scan; board_in changed mid-scan -> triangle count and order match the original snapshot; overrun_out=1.
- reset_n_in low during EMIT0 (not clock-aligned) -> tri_valid_out=0 immediately; after release, IDLE with no output until the next start pulse.
